sram_port0_arbiter: RTL and testbench
=====================================

Name: sram_port0_arbiter

Overview:
- Shares the single read/write port (port 0) of the 8x1024 1rw1r SRAM macro between two requesters: A = MAC RX frame writer, B = host/CPU buffer access.
- Registers every SRAM control input and tracks up to two in-flight accesses.
- Routes read data back to the requester that issued the read.
- Sits between the MAC datapath/host bus and the SRAM macro. Port 1 (read-only) is outside its scope.

Parameters:
- ADDR_W, 10, SRAM word address width.
- DATA_W, 8, SRAM data width.
- NUM_WMASKS, 1, write-mask bit count; DATA_W/NUM_WMASKS bits per mask bit.

Ports:
- clk  in  1  single clock; drives clk0 of the macro.
- rst_n  in  1  asynchronous, active-low reset.
- a_valid / b_valid  in  1  request present.
- a_ready / b_ready  out  1  request accepted this cycle; combinational.
- a_we / b_we  in  1  1 = write, 0 = read.
- a_wmask / b_wmask  in  NUM_WMASKS  byte write enables.
- a_addr / b_addr  in  ADDR_W  word address.
- a_wdata / b_wdata  in  DATA_W  write data.
- a_rvalid / b_rvalid  out  1  read data valid this cycle.
- a_rdata / b_rdata  out  DATA_W  read data; equals dout0, qualified only by rvalid.
- csb0  out  1  SRAM chip select, active-low; registered.
- web0  out  1  SRAM write enable, active-low; registered.
- wmask0  out  NUM_WMASKS  SRAM write mask; registered.
- addr0  out  ADDR_W  SRAM address; registered.
- din0  out  DATA_W  SRAM write data; registered.
- dout0  in  DATA_W  SRAM read data.

Behaviour:
- Reset (async assert, sync release):
  - csb0=1, web0=1, wmask0=0, addr0=0, din0=0.
  - a_rvalid=b_rvalid=0, in-flight pipeline cleared, RR pointer = A.
- Handshake:
  - Transfer occurs in cycle C when x_valid & x_ready.
  - At most one of a_ready/b_ready is high per cycle.
  - x_ready is never high without x_valid.
  - A requester holds valid and payload stable until ready.
- Arbitration (default): fixed priority, A over B. B is granted only when a_valid=0.
- Issue timing:
  - Accepted request is registered onto csb0=0, web0=~we, wmask0, addr0, din0 during cycle C+1.
  - The macro captures it at the end of C+1.
  - With no accept in C: csb0=1, web0=1 in C+1; other outputs hold their last values.
- Read return:
  - Read accepted in C gives x_rvalid=1 in cycle C+2, rdata=dout0.
  - Tracked by a 2-stage tag pipe {is_read, id}.
- Throughput and ordering:
  - One access per cycle; back-to-back mixed reads/writes from either requester need no bubbles.
  - Returns are strictly in issue order.
  - a_rvalid and b_rvalid are never high together.
- Writes produce no response.
- Read-after-write to the same address on consecutive accepts returns the new data; the macro is write-first across cycles, and no forwarding is needed.
- Simultaneous events:
  - A request accepted in the same cycle a prior read returns is legal.
  - Requester x may issue while its own rvalid is high.
- Reset mid-operation: in-flight reads are dropped (no rvalid after reset), csb0 forced to 1 immediately.

Optional Feature:
- Macro: SRAM_ARB_ROUND_ROBIN_EN.
- Defined:
  - When both a_valid and b_valid are high, grant the requester not granted at the last contended accept; the pointer updates only on contended accepts.
  - Uncontended requests are granted immediately.
  - Pointer resets to A, so the first contended grant goes to A.
- Undefined: fixed A-over-B priority; B may starve while A is continuously valid.

Test Plan:
- Writes then reads: A writes 0x55@0x00A, 0x44@0x00B, 0x33@0x00C back-to-back, then A reads 0x00A, 0x00B, 0x00C back-to-back -> a_rvalid in three consecutive cycles, each exactly 2 cycles after its accept, a_rdata 0x55, 0x44, 0x33; b_rvalid stays 0.
- Contention, fixed priority: a_valid and b_valid held high for 4 cycles -> a_ready high all 4 cycles, b_ready 0; B granted in the first cycle after a_valid drops.
- Contention, SRAM_ARB_ROUND_ROBIN_EN defined: A and B both read continuously -> grants alternate A, B, A, B; rvalid alternates a, b, a, b with matching data.
- Interleaved return routing: B writes 0xC3@0x3FF; A reads 0x000 (preloaded 0x11) in cycle C; B reads 0x3FF in C+1 -> a_rvalid in C+2 with 0x11, b_rvalid in C+3 with 0xC3.
- Idle and write-mask: no requests -> csb0=1, web0=1 every cycle. A writes wmask=0 to 0x005 (preloaded 0x5A), then reads it -> returns 0x5A.
- Async reset: rst_n pulsed low between accept and return of an A read -> a_rvalid never asserts, csb0=1 while reset is low, and normal operation resumes on the first cycle after release.

Source files
------------

// File: rtl/sram_port0_arbiter.sv
// Shares port 0 of the 1rw1r SRAM between A (MAC RX writer) and B (host); macro controls are registered.
// Optional: define SRAM_ARB_ROUND_ROBIN_EN to alternate contended grants instead of fixed A-over-B priority.
module sram_port0_arbiter #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 8,
  parameter int NUM_WMASKS = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic                  a_we,
  input  logic [NUM_WMASKS-1:0] a_wmask,
  input  logic [ADDR_W-1:0]     a_addr,
  input  logic [DATA_W-1:0]     a_wdata,
  output logic                  a_rvalid,
  output logic [DATA_W-1:0]     a_rdata,
  input  logic                  b_valid,
  output logic                  b_ready,
  input  logic                  b_we,
  input  logic [NUM_WMASKS-1:0] b_wmask,
  input  logic [ADDR_W-1:0]     b_addr,
  input  logic [DATA_W-1:0]     b_wdata,
  output logic                  b_rvalid,
  output logic [DATA_W-1:0]     b_rdata,
  output logic                  csb0,
  output logic                  web0,
  output logic [NUM_WMASKS-1:0] wmask0,
  output logic [ADDR_W-1:0]     addr0,
  output logic [DATA_W-1:0]     din0,
  input  logic [DATA_W-1:0]     dout0
);
  typedef struct packed {
    logic is_read;
    logic is_b;
  } tag_t;

  logic                  grant_a, grant_b;
  logic                  csb0_q, csb0_d, web0_q, web0_d;
  logic [NUM_WMASKS-1:0] wmask0_q, wmask0_d;
  logic [ADDR_W-1:0]     addr0_q, addr0_d;
  logic [DATA_W-1:0]     din0_q, din0_d;
  // tag_q[0] travels with the issue cycle, tag_q[1] with the data-return cycle
  tag_t [1:0]            tag_q, tag_d;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
  logic rr_b_q, rr_b_d;  // 1: B wins the next contended cycle

  always_comb begin
    grant_a = a_valid;
    grant_b = b_valid;
    rr_b_d  = rr_b_q;
    if (a_valid && b_valid) begin
      grant_a = ~rr_b_q;
      grant_b = rr_b_q;
      rr_b_d  = ~rr_b_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_b_q <= 1'b0;
    else        rr_b_q <= rr_b_d;
  end
`else
  always_comb begin
    grant_a = a_valid;
    grant_b = b_valid & ~a_valid;
  end
`endif

  always_comb begin
    csb0_d   = 1'b1;
    web0_d   = 1'b1;
    wmask0_d = wmask0_q;
    addr0_d  = addr0_q;
    din0_d   = din0_q;
    tag_d[1] = tag_q[0];
    tag_d[0] = '0;
    if (grant_a) begin
      csb0_d   = 1'b0;
      web0_d   = ~a_we;
      wmask0_d = a_wmask;
      addr0_d  = a_addr;
      din0_d   = a_wdata;
      tag_d[0] = '{is_read: ~a_we, is_b: 1'b0};
    end else if (grant_b) begin
      csb0_d   = 1'b0;
      web0_d   = ~b_we;
      wmask0_d = b_wmask;
      addr0_d  = b_addr;
      din0_d   = b_wdata;
      tag_d[0] = '{is_read: ~b_we, is_b: 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csb0_q   <= 1'b1;
      web0_q   <= 1'b1;
      wmask0_q <= '0;
      addr0_q  <= '0;
      din0_q   <= '0;
      tag_q    <= '0;
    end else begin
      csb0_q   <= csb0_d;
      web0_q   <= web0_d;
      wmask0_q <= wmask0_d;
      addr0_q  <= addr0_d;
      din0_q   <= din0_d;
      tag_q    <= tag_d;
    end
  end

  assign a_ready  = grant_a;
  assign b_ready  = grant_b;
  assign csb0     = csb0_q;
  assign web0     = web0_q;
  assign wmask0   = wmask0_q;
  assign addr0    = addr0_q;
  assign din0     = din0_q;
  assign a_rvalid = tag_q[1].is_read & ~tag_q[1].is_b;
  assign b_rvalid = tag_q[1].is_read & tag_q[1].is_b;
  assign a_rdata  = dout0;
  assign b_rdata  = dout0;
endmodule

// File: tb/tb_sram_port0_arbiter.sv
// Bench for sram_port0_arbiter: SRAM macro model, scoreboard monitor and directed/random scenario tasks.
module tb_sram_port0_arbiter;
  localparam int AW = 10;
  localparam int DW = 8;
  localparam int MW = 1;
  localparam int SL = DW / MW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          a_valid, a_ready, a_we, a_rvalid;
  logic [MW-1:0] a_wmask;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_wdata, a_rdata;
  logic          b_valid, b_ready, b_we, b_rvalid;
  logic [MW-1:0] b_wmask;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_wdata, b_rdata;
  logic          csb0, web0;
  logic [MW-1:0] wmask0;
  logic [AW-1:0] addr0;
  logic [DW-1:0] din0, dout0;

  sram_port0_arbiter #(.ADDR_W(AW), .DATA_W(DW), .NUM_WMASKS(MW)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_we(a_we), .a_wmask(a_wmask), .a_addr(a_addr),
    .a_wdata(a_wdata), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_valid(b_valid), .b_ready(b_ready), .b_we(b_we), .b_wmask(b_wmask), .b_addr(b_addr),
    .b_wdata(b_wdata), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0), .din0(din0), .dout0(dout0)
  );

  always #5 clk = ~clk;

  // Macro model: captures registered controls at the clock edge, read data appears next cycle.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (!csb0) begin
      if (!web0) begin
        for (int m = 0; m < MW; m++)
          if (wmask0[m]) mem[addr0][m*SL +: SL] <= din0[m*SL +: SL];
      end else begin
        dout0 <= mem[addr0];
      end
    end
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit mon_en = 0;
  always @(posedge clk) cyc++;

  // Reference: word-level memory updated at accept time, plus an in-order queue of expected returns.
  typedef struct {
    int          due;
    bit          is_b;
    bit          chk;
    logic [DW-1:0] data;
  } ret_t;
  ret_t          rq[$];
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  bit            known [0:(1<<AW)-1];
  bit            prev_acc, prev_we;
  logic [AW-1:0] prev_addr;
  logic [DW-1:0] prev_din;
  logic [MW-1:0] prev_mask;
  bit            last_win_b = 1'b1;

  always @(negedge clk) begin
    if (mon_en) begin
      if (!rst_n) begin
        rq.delete();
        prev_acc = 1'b0;
        last_win_b = 1'b1;
        checks++;
        if (csb0 !== 1'b1 || a_rvalid !== 1'b0 || b_rvalid !== 1'b0) begin
          errors++;
          $display("FAIL in_reset csb0=%b a_rvalid=%b b_rvalid=%b expected 1 0 0", csb0, a_rvalid, b_rvalid);
        end
      end else begin : mon
        bit ea, eb, ev_a, ev_b, dchk, tb_b, twe;
        logic [DW-1:0] ed, rd, twd;
        logic [AW-1:0] tad;
        logic [MW-1:0] tm;
        ret_t r;
        checks++;
        if (prev_acc ? (csb0 !== 1'b0 || web0 !== !prev_we || addr0 !== prev_addr ||
                        din0 !== prev_din || wmask0 !== prev_mask)
                     : (csb0 !== 1'b1 || web0 !== 1'b1)) begin
          errors++;
          $display("FAIL issue csb0=%b web0=%b addr0=%h din0=%h wmask0=%b expected acc=%0b we=%b addr=%h din=%h mask=%b",
                   csb0, web0, addr0, din0, wmask0, prev_acc, prev_we, prev_addr, prev_din, prev_mask);
        end
`ifdef SRAM_ARB_ROUND_ROBIN_EN
        if (a_valid && b_valid) begin ea = last_win_b; eb = !last_win_b; end
        else begin ea = a_valid; eb = b_valid; end
`else
        ea = a_valid;
        eb = b_valid && !a_valid;
`endif
        checks++;
        if (a_ready !== ea || b_ready !== eb) begin
          errors++;
          $display("FAIL grant a_ready=%b b_ready=%b expected %b %b", a_ready, b_ready, ea, eb);
        end
        ev_a = 1'b0; ev_b = 1'b0; ed = '0; dchk = 1'b0;
        if (rq.size() > 0 && rq[0].due == cyc) begin
          r = rq.pop_front();
          ev_a = !r.is_b; ev_b = r.is_b; ed = r.data; dchk = r.chk;
        end
        checks++;
        if (a_rvalid !== ev_a || b_rvalid !== ev_b) begin
          errors++;
          $display("FAIL rvalid a=%b b=%b expected %b %b", a_rvalid, b_rvalid, ev_a, ev_b);
        end
        if (dchk) begin
          rd = ev_b ? b_rdata : a_rdata;
          checks++;
          if (rd !== ed) begin
            errors++;
            $display("FAIL rdata got=%h expected=%h (b=%0b)", rd, ed, ev_b);
          end
        end
        prev_acc = 1'b0;
        if ((a_valid && a_ready) || (b_valid && b_ready)) begin
          tb_b = !(a_valid && a_ready);
          twe = tb_b ? b_we : a_we;
          tad = tb_b ? b_addr : a_addr;
          twd = tb_b ? b_wdata : a_wdata;
          tm  = tb_b ? b_wmask : a_wmask;
          prev_acc = 1'b1; prev_we = twe; prev_addr = tad; prev_din = twd; prev_mask = tm;
          if (a_valid && b_valid) last_win_b = tb_b;
          if (twe) begin
            for (int m = 0; m < MW; m++)
              if (tm[m]) ref_mem[tad][m*SL +: SL] = twd[m*SL +: SL];
            if (&tm) known[tad] = 1'b1;
          end else begin
            r.due = cyc + 2; r.is_b = tb_b; r.chk = known[tad]; r.data = ref_mem[tad];
            rq.push_back(r);
          end
        end
      end
    end
  end

  task automatic set_a(input bit v, input bit we, input logic [AW-1:0] ad, input logic [DW-1:0] d,
                       input logic [MW-1:0] m);
    a_valid = v; a_we = we; a_addr = ad; a_wdata = d; a_wmask = m;
  endtask

  task automatic set_b(input bit v, input bit we, input logic [AW-1:0] ad, input logic [DW-1:0] d,
                       input logic [MW-1:0] m);
    b_valid = v; b_we = we; b_addr = ad; b_wdata = d; b_wmask = m;
  endtask

  task automatic idle(input int n);
    set_a(1'b0, 1'b0, '0, '0, '0);
    set_b(1'b0, 1'b0, '0, '0, '0);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    set_a(1'b0, 1'b0, '0, '0, '0);
    set_b(1'b0, 1'b0, '0, '0, '0);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (csb0 !== 1'b1 || web0 !== 1'b1 || wmask0 !== '0 || addr0 !== '0 || din0 !== '0 ||
        a_rvalid !== 1'b0 || b_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL reset csb0=%b web0=%b wmask0=%b addr0=%h din0=%h rv=%b%b expected 1 1 0 000 00 00",
               csb0, web0, wmask0, addr0, din0, a_rvalid, b_rvalid);
    end
    #2 rst_n = 1'b1;
    mon_en = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_contention();
    bit ar [8], br [8], av [8], bv [8];
    int na = 0, nb = 0;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
    for (int k = 0; k < 8; k++) begin
      if (k < 4) begin
        set_a(1'b1, 1'b0, AW'(16 + na), '0, '1);
        set_b(1'b1, 1'b0, AW'(32 + nb), '0, '1);
      end else begin
        set_a(1'b0, 1'b0, '0, '0, '0);
        set_b(1'b0, 1'b0, '0, '0, '0);
      end
      @(negedge clk);
      ar[k] = a_ready; br[k] = b_ready; av[k] = a_rvalid; bv[k] = b_rvalid;
      if (a_ready) na++;
      if (b_ready) nb++;
      @(posedge clk); #1;
    end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (ar[k] !== (k < 4 && k % 2 == 0) || br[k] !== (k < 4 && k % 2 == 1)) begin
        errors++;
        $display("FAIL rr_grant k=%0d a_ready=%b b_ready=%b expected %b %b", k, ar[k], br[k],
                 k < 4 && k % 2 == 0, k < 4 && k % 2 == 1);
      end
      checks++;
      if (av[k] !== (k >= 2 && k < 6 && k % 2 == 0) || bv[k] !== (k >= 2 && k < 6 && k % 2 == 1)) begin
        errors++;
        $display("FAIL rr_return k=%0d a_rvalid=%b b_rvalid=%b", k, av[k], bv[k]);
      end
    end
`else
    for (int k = 0; k < 5; k++) begin
      set_a(k < 4, 1'b0, AW'(16 + k), '0, '1);
      set_b(1'b1, 1'b0, AW'(32), '0, '1);
      @(negedge clk);
      ar[k] = a_ready; br[k] = b_ready;
      @(posedge clk); #1;
    end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (ar[k] !== (k < 4) || br[k] !== (k == 4)) begin
        errors++;
        $display("FAIL fixed_prio k=%0d a_ready=%b b_ready=%b expected %b %b", k, ar[k], br[k], k < 4, k == 4);
      end
    end
    na = 0; nb = 0; av[0] = 1'b0; bv[0] = 1'b0;
`endif
    idle(3);
  endtask

  task automatic test_writes_then_reads();
    logic [DW-1:0] ex [3];
    bit av [6], bv [6];
    logic [DW-1:0] ad [6];
    ex[0] = 8'h55; ex[1] = 8'h44; ex[2] = 8'h33;
    for (int k = 0; k < 3; k++) begin
      set_a(1'b1, 1'b1, AW'(10 + k), ex[k], '1);
      @(posedge clk); #1;
    end
    for (int k = 0; k < 6; k++) begin
      set_a(k < 3, 1'b0, AW'(10 + k), '0, '1);
      @(negedge clk);
      av[k] = a_rvalid; bv[k] = b_rvalid; ad[k] = a_rdata;
      @(posedge clk); #1;
    end
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (av[k] !== (k >= 2 && k <= 4) || bv[k] !== 1'b0) begin
        errors++;
        $display("FAIL wr_rd_valid k=%0d a_rvalid=%b b_rvalid=%b expected %b 0", k, av[k], bv[k], k >= 2 && k <= 4);
      end
      if (k >= 2 && k <= 4) begin
        checks++;
        if (ad[k] !== ex[k-2]) begin
          errors++;
          $display("FAIL wr_rd_data k=%0d got=%h expected=%h", k, ad[k], ex[k-2]);
        end
      end
    end
    idle(1);
  endtask

  task automatic test_interleave();
    bit av [5], bv [5];
    logic [DW-1:0] ad [5], bd [5];
    set_a(1'b1, 1'b1, 10'h000, 8'h11, '1);
    @(posedge clk); #1;
    set_a(1'b0, 1'b0, '0, '0, '0);
    set_b(1'b1, 1'b1, 10'h3FF, 8'hC3, '1);
    @(posedge clk); #1;
    for (int k = 0; k < 5; k++) begin
      set_a(k == 0, 1'b0, 10'h000, '0, '1);
      set_b(k == 1, 1'b0, 10'h3FF, '0, '1);
      @(negedge clk);
      av[k] = a_rvalid; bv[k] = b_rvalid; ad[k] = a_rdata; bd[k] = b_rdata;
      @(posedge clk); #1;
    end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (av[k] !== (k == 2) || bv[k] !== (k == 3)) begin
        errors++;
        $display("FAIL interleave_valid k=%0d a=%b b=%b expected %b %b", k, av[k], bv[k], k == 2, k == 3);
      end
    end
    checks++;
    if (ad[2] !== 8'h11 || bd[3] !== 8'hC3) begin
      errors++;
      $display("FAIL interleave_data a=%h b=%h expected 11 c3", ad[2], bd[3]);
    end
    idle(1);
  endtask

  task automatic test_idle_wmask();
    bit av [4];
    logic [DW-1:0] ad [4];
    idle(2);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (csb0 !== 1'b1 || web0 !== 1'b1) begin
        errors++;
        $display("FAIL idle k=%0d csb0=%b web0=%b expected 1 1", k, csb0, web0);
      end
      @(posedge clk); #1;
    end
    set_a(1'b1, 1'b1, 10'h005, 8'h5A, '1);
    @(posedge clk); #1;
    set_a(1'b1, 1'b1, 10'h005, 8'hFF, '0);
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) begin
      set_a(k == 0, 1'b0, 10'h005, '0, '1);
      @(negedge clk);
      av[k] = a_rvalid; ad[k] = a_rdata;
      @(posedge clk); #1;
    end
    checks++;
    if (av[0] !== 1'b0 || av[1] !== 1'b0 || av[2] !== 1'b1 || av[3] !== 1'b0 || ad[2] !== 8'h5A) begin
      errors++;
      $display("FAIL wmask0_keep rvalid=%b%b%b%b data=%h expected 0010 5a", av[0], av[1], av[2], av[3], ad[2]);
    end
    idle(1);
  endtask

  task automatic test_async_reset();
    bit av [5];
    bit rdy;
    logic [DW-1:0] ad [5];
    set_a(1'b1, 1'b0, 10'h00A, '0, '1);
    @(posedge clk); #1;
    set_a(1'b0, 1'b0, '0, '0, '0);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (csb0 !== 1'b1) begin
      errors++;
      $display("FAIL reset_csb0_immediate csb0=%b expected 1", csb0);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (a_rvalid !== 1'b0 || csb0 !== 1'b1) begin
      errors++;
      $display("FAIL reset_drop a_rvalid=%b csb0=%b expected 0 1", a_rvalid, csb0);
    end
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    rdy = 1'b0;
    for (int k = 0; k < 5; k++) begin
      set_a(k == 0, 1'b0, 10'h00B, '0, '1);
      @(negedge clk);
      if (k == 0) rdy = a_ready;
      av[k] = a_rvalid; ad[k] = a_rdata;
      @(posedge clk); #1;
    end
    checks++;
    if (rdy !== 1'b1) begin
      errors++;
      $display("FAIL resume_ready a_ready=%b expected 1", rdy);
    end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (av[k] !== (k == 2)) begin
        errors++;
        $display("FAIL resume_valid k=%0d a_rvalid=%b expected %b", k, av[k], k == 2);
      end
    end
    checks++;
    if (ad[2] !== 8'h44) begin
      errors++;
      $display("FAIL resume_data got=%h expected=44", ad[2]);
    end
    idle(1);
  endtask

  function automatic logic [AW-1:0] rnd_addr();
    return ($urandom_range(0, 7) == 0) ? 10'h3FF : AW'($urandom_range(0, 15));
  endfunction

  task automatic test_random();
    bit acc_a = 1'b1, acc_b = 1'b1;
    for (int i = 0; i < 16; i++) begin
      set_a(1'b1, 1'b1, AW'(i), DW'($urandom), '1);
      @(posedge clk); #1;
    end
    idle(1);
    for (int i = 0; i < 400; i++) begin
      if (!a_valid || acc_a)
        set_a($urandom_range(0, 3) != 0, 1'($urandom), rnd_addr(), DW'($urandom), MW'($urandom));
      if (!b_valid || acc_b)
        set_b($urandom_range(0, 2) != 0, 1'($urandom), rnd_addr(), DW'($urandom), MW'($urandom));
      @(negedge clk);
      acc_a = a_valid && a_ready;
      acc_b = b_valid && b_ready;
      @(posedge clk); #1;
    end
    idle(4);
  endtask

  initial begin
    test_reset();
    test_contention();
    test_writes_then_reads();
    test_interleave();
    test_idle_wmask();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
